// File: rtl/adc_frame_packer_pkg.sv
// Shared definitions for the ADC frame packer: FSM state encoding, default
// header/trailer constants and the bit positions of the payload word fields.
package adc_frame_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CSUM_W   = 2 * SAMPLE_W;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;
  localparam logic [7:0]  TRL_TAG_DEF   = 8'hEF;

  // Payload word layout: {idx, sample_b, sample_a}
  localparam int unsigned IDX_MSB = 31;
  localparam int unsigned IDX_LSB = 24;
  localparam int unsigned B_MSB   = 23;
  localparam int unsigned B_LSB   = 12;
  localparam int unsigned A_MSB   = 11;
  localparam int unsigned A_LSB   = 0;

endpackage

// File: rtl/adc_frame_packer_sat_counter16.sv
// 16-bit up counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), i_inc (count enable), o_count.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/adc_frame_packer.sv
// Packs dual-channel 12-bit ADC sample pairs into 32-bit words and frames them
// for the fiber TX FIFO: header {HDR_MAGIC, seq}, FRAME_LEN payload words
// {idx, b, a}, and with ADC_PACK_CHECKSUM_EN defined a trailer {TRL_TAG, xor}.
// TRL_TAG exists only when ADC_PACK_CHECKSUM_EN is defined.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                framing enable (level)
//   adc_a, adc_b          channel samples, qualified by adc_valid
//   fifo_almost_full      sampled only when a new frame would start
//   fifo_full             a write attempted while full aborts the frame
//   wr_en, wr_data        registered FIFO write port
//   busy                  high whenever the FSM is not idle
//   frame_cnt             sequence number of the next header (wraps)
//   drop_cnt              discarded samples (saturating)
//   abort                 one-cycle pulse per aborted frame
//   overflow              sticky abort flag, cleared only by reset
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 64,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
`ifdef ADC_PACK_CHECKSUM_EN
  ,
  parameter logic [7:0]  TRL_TAG   = TRL_TAG_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] adc_a,
  input  logic [SAMPLE_W-1:0] adc_b,
  input  logic                adc_valid,
  input  logic                fifo_almost_full,
  input  logic                fifo_full,
  output logic                wr_en,
  output logic [WORD_W-1:0]   wr_data,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                abort,
  output logic                overflow
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t              r_state,     w_state_nxt;
  logic [7:0]          r_idx,       w_idx_nxt;
  logic                r_wr_en,     w_wr_en_nxt;
  logic [WORD_W-1:0]   r_wr_data,   w_wr_data_nxt;
  logic                r_busy;
  logic [CNT_W-1:0]    r_frame_cnt, w_frame_cnt_nxt;
  logic                r_abort,     w_abort_nxt;
  logic                r_overflow,  w_overflow_nxt;
  logic                w_drop_inc;
  logic                w_start_ok;
  logic                w_frame_done;
`ifdef ADC_PACK_CHECKSUM_EN
  logic [CSUM_W-1:0]   r_csum,      w_csum_nxt;
`endif

  // Next-state, next-output and counter-enable decode
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_wr_en_nxt     = 1'b0;
    w_wr_data_nxt   = r_wr_data;
    w_frame_cnt_nxt = r_frame_cnt;
    w_abort_nxt     = 1'b0;
    w_overflow_nxt  = r_overflow;
    w_drop_inc      = 1'b0;
    w_frame_done    = 1'b0;
    w_start_ok      = enable && !fifo_almost_full;
`ifdef ADC_PACK_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif

    case (r_state)
      ST_IDLE: begin
        w_drop_inc = adc_valid;
        if (w_start_ok) begin
          w_state_nxt = ST_HEADER;
        end
      end

      ST_HEADER: begin
        w_drop_inc = adc_valid;
        if (fifo_full) begin
          w_abort_nxt = 1'b1;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = {HDR_MAGIC, r_frame_cnt};
          w_idx_nxt     = '0;
`ifdef ADC_PACK_CHECKSUM_EN
          w_csum_nxt    = '0;
`endif
          w_state_nxt   = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (adc_valid) begin
          if (fifo_full) begin
            w_abort_nxt = 1'b1;
            w_drop_inc  = 1'b1;
          end else begin
            w_wr_en_nxt                    = 1'b1;
            w_wr_data_nxt                  = '0;
            w_wr_data_nxt[IDX_MSB:IDX_LSB] = r_idx;
            w_wr_data_nxt[B_MSB:B_LSB]     = adc_b;
            w_wr_data_nxt[A_MSB:A_LSB]     = adc_a;
            w_idx_nxt                      = r_idx + 8'd1;
`ifdef ADC_PACK_CHECKSUM_EN
            w_csum_nxt = r_csum ^ {adc_b, adc_a};
            if (r_idx == LAST_IDX) begin
              w_state_nxt = ST_TRAILER;
            end
`else
            w_frame_done = (r_idx == LAST_IDX);
`endif
          end
        end
      end

`ifdef ADC_PACK_CHECKSUM_EN
      ST_TRAILER: begin
        w_drop_inc = adc_valid;
        if (fifo_full) begin
          w_abort_nxt = 1'b1;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = {TRL_TAG, r_csum};
          w_frame_done  = 1'b1;
        end
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // An aborted frame keeps its sequence number for the retry
    if (w_abort_nxt) begin
      w_state_nxt    = ST_IDLE;
      w_overflow_nxt = 1'b1;
    end

    // Back-to-back frames skip IDLE when the next one may start at once
    if (w_frame_done) begin
      w_frame_cnt_nxt = r_frame_cnt + 16'd1;
      w_state_nxt     = w_start_ok ? ST_HEADER : ST_IDLE;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_abort     <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef ADC_PACK_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_frame_cnt <= w_frame_cnt_nxt;
      r_abort     <= w_abort_nxt;
      r_overflow  <= w_overflow_nxt;
`ifdef ADC_PACK_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  sat_counter16 u_drop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_drop_inc),
    .o_count (drop_cnt)
  );

  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign abort     = r_abort;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer (FRAME_LEN=4). Works with or
// without ADC_PACK_CHECKSUM_EN; a frame-position model predicts every output
// each cycle, and directed literal checks pin specific words and counters.
module tb_adc_frame_packer;

  localparam int L = 4;
`ifdef ADC_PACK_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] adc_a = '0;
  logic [11:0] adc_b = '0;
  logic        adc_valid = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        abort;
  logic        overflow;

  adc_frame_packer #(.FRAME_LEN(L)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .adc_a            (adc_a),
    .adc_b            (adc_b),
    .adc_valid        (adc_valid),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .busy             (busy),
    .frame_cnt        (frame_cnt),
    .drop_cnt         (drop_cnt),
    .abort            (abort),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_abort = 0;
  logic [31:0] cap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pos = -1 idle, 0 header slot, 1..L payload slots, L+1 trailer slot
  int          pos    = -1;
  logic [15:0] m_fc   = '0;
  logic [15:0] m_drop = '0;
  logic [23:0] m_cs   = '0;
  logic        m_ovf  = 1'b0;
  logic        e_wr_en = 1'b0;
  logic [31:0] e_wr_data = '0;
  logic        e_abort = 1'b0;
  logic        e_busy  = 1'b0;

  task automatic model_reset();
    pos = -1; m_fc = '0; m_drop = '0; m_cs = '0; m_ovf = 1'b0;
    e_wr_en = 1'b0; e_wr_data = '0; e_abort = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    bit drop, abrt, done;
    bit can_start;
    drop = 1'b0; abrt = 1'b0; done = 1'b0;
    can_start = enable && !fifo_almost_full;
    e_wr_en = 1'b0;
    e_abort = 1'b0;
    if (pos < 0) begin
      drop = adc_valid;
      if (can_start) pos = 0;
    end else if (pos == 0) begin
      drop = adc_valid;
      if (fifo_full) abrt = 1'b1;
      else begin
        e_wr_en = 1'b1; e_wr_data = {16'hA55A, m_fc}; m_cs = '0; pos = 1;
      end
    end else if (pos <= L) begin
      if (adc_valid) begin
        if (fifo_full) begin
          abrt = 1'b1; drop = 1'b1;
        end else begin
          e_wr_en = 1'b1;
          e_wr_data = {8'(pos - 1), adc_b, adc_a};
          m_cs = m_cs ^ {adc_b, adc_a};
          if (pos == L) begin
            if (CK) pos = L + 1;
            else done = 1'b1;
          end else pos++;
        end
      end
    end else begin
      drop = adc_valid;
      if (fifo_full) abrt = 1'b1;
      else begin
        e_wr_en = 1'b1; e_wr_data = {8'hEF, m_cs}; done = 1'b1;
      end
    end
    if (abrt) begin
      e_abort = 1'b1; m_ovf = 1'b1; pos = -1;
    end
    if (done) begin
      m_fc = m_fc + 16'd1;
      pos = can_start ? 0 : -1;
    end
    if (drop && (m_drop != 16'hFFFF)) m_drop = m_drop + 16'd1;
    e_busy = (pos >= 0);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle compare, capture of written words, abort pulse count
  initial forever begin
    @(negedge clk);
    check("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) check("wr_data", wr_data, e_wr_data);
    check("busy", 32'(busy), 32'(e_busy));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("abort", 32'(abort), 32'(e_abort));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (wr_en) cap.push_back(wr_data);
    if (abort) n_abort++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input bit v, input logic [11:0] a, input logic [11:0] b);
    adc_valid = v; adc_a = a; adc_b = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},     32'(wr_en), 32'd0);
    check({tag, "_wr_data"},   wr_data, 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_drop_cnt"},  32'(drop_cnt), 32'd0);
    check({tag, "_abort"},     32'(abort), 32'd0);
    check({tag, "_overflow"},  32'(overflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nom[6];
    nom[0] = 32'hA55A0000; nom[1] = 32'h00100001; nom[2] = 32'h01200002;
    nom[3] = 32'h02300003; nom[4] = 32'h03400004; nom[5] = 32'hEF400004;

    // Reset
    tick(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    tick(2);

    // Nominal frame
    cap.delete();
    enable = 1'b1;
    tick(2);
    for (int i = 1; i <= 4; i++) begin
      sample(1'b1, 12'(i), 12'(i * 256));
      if (i == 4) enable = 1'b0;
      tick(1);
    end
    sample(1'b0, '0, '0);
    tick(3);
    check("nom_len", 32'(cap.size()), 32'(5 + int'(CK)));
    for (int i = 0; i < 5 + int'(CK); i++)
      if (i < cap.size()) check($sformatf("nom_word%0d", i), cap[i], nom[i]);
    check("nom_frame_cnt", 32'(frame_cnt), 32'd1);
    check("nom_drop_cnt", 32'(drop_cnt), 32'd0);

    // Almost-full holds off framing; samples in IDLE are dropped
    cap.delete();
    fifo_almost_full = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample(1'b1, 12'h5A5, 12'hA5A);
      tick(1);
      sample(1'b0, '0, '0);
      tick(1);
    end
    tick(1);
    check("af_busy", 32'(busy), 32'd0);
    check("af_nowrite", 32'(cap.size()), 32'd0);
    check("af_drop_cnt", 32'(drop_cnt), 32'd3);
    fifo_almost_full = 1'b0;
    tick(1);
    check("af_release_busy", 32'(busy), 32'd1);
    // Sample during header slot is dropped
    sample(1'b1, 12'h0AA, 12'h0BB);
    tick(1);
    check("af_hdr_word", wr_data, 32'hA55A0001);
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, 12'(12'h010 + i), 12'(12'h020 + i));
      if (i == 3) enable = 1'b0;
      tick(1);
    end
    // Sample during trailer slot (or idle without checksum) is dropped
    sample(1'b1, 12'h777, 12'h888);
    tick(1);
    sample(1'b0, '0, '0);
    tick(3);
    check("hdr_drop_idx0", (cap.size() > 1) ? cap[1] : 32'hX, 32'h00020010);
    check("hdr_drop_idx3", (cap.size() > 4) ? cap[4] : 32'hX, 32'h03023013);
    if (CK) check("trl_zero_xor", (cap.size() > 5) ? cap[5] : 32'hX, 32'hEF000000);
    check("hd_drop_cnt", 32'(drop_cnt), 32'd5);
    check("hd_frame_cnt", 32'(frame_cnt), 32'd2);

    // Mid-frame full on the second payload sample
    cap.delete();
    enable = 1'b1;
    tick(2);
    sample(1'b1, 12'h111, 12'h222);
    tick(1);
    sample(1'b1, 12'h333, 12'h444);
    fifo_full = 1'b1;
    enable = 1'b0;
    tick(1);
    fifo_full = 1'b0;
    sample(1'b0, '0, '0);
    check("ab_abort", 32'(abort), 32'd1);
    check("ab_overflow", 32'(overflow), 32'd1);
    check("ab_drop_cnt", 32'(drop_cnt), 32'd6);
    check("ab_frame_cnt", 32'(frame_cnt), 32'd2);
    tick(1);
    check("ab_pulse_end", 32'(abort), 32'd0);
    check("ab_written", 32'(cap.size()), 32'd2);
    enable = 1'b1;
    tick(2);
    check("ab_retry_hdr", wr_data, 32'hA55A0002);
    enable = 1'b0;
    sample(1'b1, 12'h001, 12'h002);
    tick(1);
    sample(1'b1, 12'h003, 12'h004);
    tick(1);
    sample(1'b0, '0, '0);
    // full without a sample does not abort
    fifo_full = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    check("full_idle_no_abort", 32'(abort), 32'd0);

    // Reset mid-frame clears everything immediately
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Post-reset frame restarts at sequence 0; gap in samples mid-frame
    cap.delete();
    enable = 1'b1;
    tick(2);
    sample(1'b1, 12'h00A, 12'h00B); tick(1);
    sample(1'b1, 12'h00C, 12'h00D); tick(1);
    sample(1'b0, '0, '0);           tick(1);
    sample(1'b1, 12'h00E, 12'h00F); tick(1);
    enable = 1'b0;
    sample(1'b1, 12'h010, 12'h011); tick(1);
    sample(1'b0, '0, '0);
    tick(4);
    check("post_hdr", (cap.size() > 0) ? cap[0] : 32'hX, 32'hA55A0000);
    check("post_len", 32'(cap.size()), 32'(5 + int'(CK)));
    check("post_frame_cnt", 32'(frame_cnt), 32'd1);
    check("post_overflow", 32'(overflow), 32'd0);
    check("abort_pulses", 32'(n_abort), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
